// File: rtl/char_scroller_pkg.sv
// Shared definitions for the character scroller: state encoding, slot
// geometry and rotation direction codes.
package char_scroller_pkg;

  // Slot geometry of the 2-bit character path.
  localparam int NCHAR = 4;
  localparam int CW    = 2;

  // Rotation direction as seen on the dir input.
  localparam logic DIR_LEFT  = 1'b0;  // toward HEX3
  localparam logic DIR_RIGHT = 1'b1;  // toward HEX0

  // Control states; the encoding is fixed so other board blocks can
  // decode it if the state is ever exported.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

endpackage

// File: rtl/char_scroller_tick_prescaler.sv
// Free-running divider: with en high it counts 0..TICK_DIV-1 and raises a
// one-cycle tick while sitting on the terminal count. With en low it holds
// its value, so a paused interval resumes where it stopped. clr restarts
// the interval and suppresses any tick in the same cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A divide-by-1 still needs a one-bit counter to stay well formed.
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] TERM = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = en && !clr && (count == TERM);

  // Interval counter: clear wins, then wrap at terminal count, else count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == TERM) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/char_scroller.sv
// Holds four 2-bit character codes and rotates them across the four digit
// slots at a rate set by TICK_DIV. sel tracks the rotation position so the
// downstream 4:1 selector can follow the scroll.
module char_scroller #(
  parameter int TICK_DIV = 50000000,
  parameter int NCHAR    = 4,
  parameter int CW       = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NCHAR*CW-1:0]      data,
  input  logic                     run,
  input  logic                     dir,
  output logic [NCHAR*CW-1:0]      chars,
  output logic [$clog2(NCHAR)-1:0] sel,
  output logic                     step,
  output logic                     loaded
);

  import char_scroller_pkg::*;

  localparam int DW = NCHAR * CW;
  localparam int SW = $clog2(NCHAR);

  state_t state;
  state_t state_nxt;
  logic   count_en;
  logic   tick;

  // run is qualified by the current state, so a run that drops in the
  // would-be tick cycle stops the count before the tick can fire.
  assign count_en = (state == SCROLL) && run;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (CLOCK_50),
    .rst  (reset),
    .en   (count_en),
    .clr  (load),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: only EMPTY reacts to load; afterwards run alone
  // chooses between frozen and scrolling.
  always_comb begin
    // NOTE: defaulting every output of a combinational block first keeps
    // unlisted paths from inferring latches.
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (load) begin
          state_nxt = run ? SCROLL : HOLD;
        end
      end
      HOLD: begin
        if (run) begin
          state_nxt = SCROLL;
        end
      end
      SCROLL: begin
        if (!run) begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Character, position and status registers: load beats a rotation step,
  // and dir is only looked at on the tick itself.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: every output flop is cleared by the async reset so the display
    // blanks immediately; there are no memories here to leave uninitialised.
    if (reset) begin
      chars  <= '0;
      sel    <= '0;
      step   <= 1'b0;
      loaded <= 1'b0;
    end else begin
      step <= tick;
      if (load) begin
        chars  <= data;
        sel    <= '0;
        loaded <= 1'b1;
      end else if (tick) begin
        if (dir == DIR_LEFT) begin
          chars <= {chars[DW-CW-1:0], chars[DW-1 -: CW]};
          sel   <= sel + SW'(1);
        end else begin
          chars <= {chars[CW-1:0], chars[DW-1:CW]};
          sel   <= sel - SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_char_scroller.sv
// Directed bench for char_scroller with a divide-by-4 prescaler. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
module tb_char_scroller;

  logic       CLOCK_50;
  logic       reset;
  logic       load;
  logic [7:0] data;
  logic       run;
  logic       dir;
  logic [7:0] chars;
  logic [1:0] sel;
  logic       step;
  logic       loaded;

  int checks = 0;
  int errors = 0;

  char_scroller #(
    .TICK_DIV(4),
    .NCHAR   (4),
    .CW      (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (load),
    .data     (data),
    .run      (run),
    .dir      (dir),
    .chars    (chars),
    .sel      (sel),
    .step     (step),
    .loaded   (loaded)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] c, input logic [1:0] s,
                           input logic st, input logic ld);
    check({tag, ".chars"},  chars,          c);
    check({tag, ".sel"},    {6'd0, sel},    {6'd0, s});
    check({tag, ".step"},   {7'd0, step},   {7'd0, st});
    check({tag, ".loaded"}, {7'd0, loaded}, {7'd0, ld});
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    data  = 8'h00;
    run   = 1'b0;
    dir   = 1'b0;
    repeat (2) cyc();
    check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // run without load: stays EMPTY, nothing moves.
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("empty.step", {7'd0, step}, 8'd0);
      check("empty.chars", chars, 8'h00);
    end
    check("empty.loaded", {7'd0, loaded}, 8'd0);

    // Load E4 scrolling left.
    load = 1'b1;
    data = 8'hE4;
    dir  = 1'b0;
    cyc();
    load = 1'b0;
    check_out("loadL", 8'hE4, 2'd0, 1'b0, 1'b1);
    repeat (3) begin
      cyc();
      check("loadL.nostep", {7'd0, step}, 8'd0);
    end
    cyc();
    check_out("left1", 8'h93, 2'd1, 1'b1, 1'b1);
    repeat (3) cyc();
    cyc();
    check_out("left2", 8'h4E, 2'd2, 1'b1, 1'b1);
    repeat (3) cyc();
    cyc();
    check_out("left3", 8'h39, 2'd3, 1'b1, 1'b1);
    repeat (3) cyc();
    cyc();
    check_out("left4", 8'hE4, 2'd0, 1'b1, 1'b1);

    // Pause two cycles after a step; prescaler freezes at 2.
    repeat (2) cyc();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold.chars", chars, 8'hE4);
      check("hold.step", {7'd0, step}, 8'd0);
    end
    run = 1'b1;
    cyc();  // HOLD -> SCROLL
    check("resume1.step", {7'd0, step}, 8'd0);
    cyc();  // count 2 -> 3
    check("resume2.step", {7'd0, step}, 8'd0);
    cyc();  // tick
    check_out("resume", 8'h93, 2'd1, 1'b1, 1'b1);

    // Load lands on the tick cycle: load wins, interval restarts.
    repeat (3) cyc();
    load = 1'b1;
    data = 8'h1B;
    cyc();
    load = 1'b0;
    check_out("loadtick", 8'h1B, 2'd0, 1'b0, 1'b1);
    repeat (3) begin
      cyc();
      check("loadtick.nostep", {7'd0, step}, 8'd0);
    end
    cyc();
    check_out("loadtick.step", 8'h6C, 2'd1, 1'b1, 1'b1);

    // Right rotation from E4, including the 0 -> 3 wrap of sel.
    load = 1'b1;
    data = 8'hE4;
    dir  = 1'b1;
    cyc();
    load = 1'b0;
    check_out("loadR", 8'hE4, 2'd0, 1'b0, 1'b1);
    repeat (3) cyc();
    cyc();
    check_out("right1", 8'h39, 2'd3, 1'b1, 1'b1);
    repeat (3) cyc();
    cyc();
    check_out("right2", 8'h4E, 2'd2, 1'b1, 1'b1);

    // run drops in the would-be tick cycle: no rotation.
    repeat (3) cyc();
    run = 1'b0;
    cyc();
    check_out("runfall", 8'h4E, 2'd2, 1'b0, 1'b1);
    repeat (5) cyc();
    check("runfall.hold", chars, 8'h4E);

    // Resume from frozen count 3: one cycle to re-enter SCROLL, then tick.
    run = 1'b1;
    cyc();
    check("resume3.step", {7'd0, step}, 8'd0);
    cyc();
    check_out("right3", 8'h93, 2'd1, 1'b1, 1'b1);

    // Asynchronous reset between edges while step is high.
    #2;
    reset = 1'b1;
    #1;
    check_out("asyncrst", 8'h00, 2'd0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("postrst.chars", chars, 8'h00);
      check("postrst.step", {7'd0, step}, 8'd0);
    end
    check("postrst.loaded", {7'd0, loaded}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
